// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline types and sizes used by the register-file scoreboard.
package rv32_pkg;
  localparam int RF_NUM_REGS    = 32;
  localparam int RF_ADDR_W      = 5;
  localparam int SB_CNT_W       = 2;
  localparam int SB_STALL_CNT_W = 16;

  // Issue-side view of an instruction, as decode drives it into the scoreboard.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rs1_sel;
    logic                 rs1_used;
    logic [RF_ADDR_W-1:0] rs2_sel;
    logic                 rs2_used;
    logic [RF_ADDR_W-1:0] rd_sel;
    logic                 rd_wen;
  } rv32_sb_issue_req_t;
endpackage

// File: rtl/sb_reg_counter.sv
// Pending-write counter for one architectural register.
module sb_reg_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  output logic busy,
  output logic at_max
);
  logic [CNT_W-1:0] cnt;

  // A simultaneous issue and writeback to the same register cancel out.
  always_ff @(posedge clk) begin
    if (reset || clr)     cnt <= '0;
    else if (inc && !dec) cnt <= cnt + 1'b1;
    else if (dec && !inc) cnt <= cnt - 1'b1;
  end

  assign busy   = |cnt;
  assign at_max = &cnt;
endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side scoreboard: blocks reads of registers with writebacks in flight.
import rv32_pkg::*;

module regfile_scoreboard #(
  parameter int NUM_REGS    = RF_NUM_REGS,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter int CNT_W       = SB_CNT_W,
  parameter int STALL_CNT_W = SB_STALL_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rs1_sel,
  input  logic                   issue_rs1_used,
  input  logic [ADDR_W-1:0]      issue_rs2_sel,
  input  logic                   issue_rs2_used,
  input  logic [ADDR_W-1:0]      issue_rd_sel,
  input  logic                   issue_rd_wen,
  output logic                   issue_ready,
  input  logic                   wb_enable,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic                   flush,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic                   hazard_rs1,
  output logic                   hazard_rs2,
  output logic                   wb_underflow,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  rv32_sb_issue_req_t     req;
  logic [NUM_REGS-1:0]    busy, at_max;
  logic                   sat_stall, fire, inc_any, dec_any, uf_set;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   uf_q;

  assign req = '{valid: issue_valid, rs1_sel: issue_rs1_sel, rs1_used: issue_rs1_used,
                 rs2_sel: issue_rs2_sel, rs2_used: issue_rs2_used,
                 rd_sel: issue_rd_sel, rd_wen: issue_rd_wen};

  // x0 is hardwired zero and never pending.
  assign busy[0]   = 1'b0;
  assign at_max[0] = 1'b0;

  generate
    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
      sb_reg_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .inc    (inc_any && (req.rd_sel == ADDR_W'(r))),
        .dec    (dec_any && (wb_addr == ADDR_W'(r))),
        .clr    (flush),
        .busy   (busy[r]),
        .at_max (at_max[r])
      );
    end
  endgenerate

  // Hazards look at registered busy only; a same-cycle writeback does not release.
  assign hazard_rs1  = req.valid && req.rs1_used && (req.rs1_sel != '0) && busy[req.rs1_sel];
  assign hazard_rs2  = req.valid && req.rs2_used && (req.rs2_sel != '0) && busy[req.rs2_sel];
  assign sat_stall   = req.valid && req.rd_wen && (req.rd_sel != '0) && at_max[req.rd_sel];
  assign issue_ready = !(hazard_rs1 || hazard_rs2 || sat_stall || flush);

  assign fire    = req.valid && issue_ready;
  assign inc_any = fire && req.rd_wen && (req.rd_sel != '0);
  assign dec_any = wb_enable && (wb_addr != '0) && busy[wb_addr];
  assign uf_set  = wb_enable && (wb_addr != '0) && !busy[wb_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      if (req.valid && !issue_ready && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (uf_set) uf_q <= 1'b1;
    end
  end

  assign busy_vec     = busy;
  assign stall_cnt    = stall_q;
  assign wb_underflow = uf_q;
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Issue-side controller for the 32-entry RV32 register file in the in-order single-issue pipeline.
- Tracks every register with a writeback still in flight, and holds the decode/issue stage while an instruction would read a stale value through the asynchronous read ports.
- Releases each pending register when the matching writeback packet commits it.
- Also provides a flush path and a saturating stall-cycle performance counter.

Parameters:
NUM_REGS, 32, number of architectural registers tracked
ADDR_W, 5, register address width
CNT_W, 2, width of the per-register pending-write counter (max 2^CNT_W-1 outstanding writes per register)
STALL_CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  instruction present at the register-file stage
issue_rs1_sel  in  ADDR_W  source register 1 address
issue_rs1_used  in  1  instruction reads rs1
issue_rs2_sel  in  ADDR_W  source register 2 address
issue_rs2_used  in  1  instruction reads rs2
issue_rd_sel  in  ADDR_W  destination register address
issue_rd_wen  in  1  instruction will write rd
issue_ready  out  1  instruction may advance this cycle (fire = issue_valid & issue_ready)
wb_enable  in  1  writeback commits this cycle (same signal that drives the register-file write)
wb_addr  in  ADDR_W  register written by the writeback
flush  in  1  pipeline flush; all in-flight writes are discarded
busy_vec  out  NUM_REGS  bit r = register r has at least one pending write
hazard_rs1  out  1  rs1 read blocked this cycle
hazard_rs2  out  1  rs2 read blocked this cycle
wb_underflow  out  1  sticky error: writeback arrived for a register with zero pending writes
stall_cnt  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: all counters 0, busy_vec 0, wb_underflow 0, stall_cnt 0. Combinational outputs follow from this: issue_ready 1 and hazards 0 when issue_valid=0.
- Register x0 is never tracked:
  - rd_sel=0 does not increment.
  - rs_sel=0 never raises a hazard.
  - wb_addr=0 never decrements and never flags underflow.
- Per register r, cnt[r] is CNT_W bits wide; busy_vec[r] = (cnt[r] != 0). busy_vec is registered state.
- hazard_rs1 = issue_valid & issue_rs1_used & (rs1_sel != 0) & busy[rs1_sel]. hazard_rs2 is symmetric.
- No same-cycle release: if wb_enable hits rs1_sel in the same cycle, the hazard still holds that cycle. The register file only captures the write at the clock edge, so issue_ready rises at the earliest on the following cycle.
- sat_stall = issue_valid & issue_rd_wen & (rd_sel != 0) & (cnt[rd_sel] == max).
- WAW hazards do not stall. Writebacks are in order, so the counter simply increments.
- issue_ready = !(hazard_rs1 | hazard_rs2 | sat_stall | flush). It is purely combinational, with no dependency on any downstream ready.
- Counter update at each posedge, when reset=0 and flush=0:
  - inc = fire & issue_rd_wen & (rd_sel != 0).
  - dec = wb_enable & (wb_addr != 0) & (cnt[wb_addr] != 0).
  - If inc and dec target the same register, the count is unchanged.
  - Otherwise apply +1 to rd_sel and -1 to wb_addr independently.
- Underflow: wb_enable with wb_addr != 0 and cnt[wb_addr] == 0 sets wb_underflow. The counter stays 0, and the flag is cleared only by reset.
- Flush:
  - All counters are cleared to 0 on the next edge, overriding inc and dec in that cycle; a wb in the flush cycle is not counted.
  - issue_ready is forced to 0 during flush.
  - wb_underflow and stall_cnt are unaffected.
- stall_cnt increments on every cycle with issue_valid & !issue_ready, and saturates at all-ones (no wrap).
- Reset has priority over flush and all updates. Reset asserted mid-stall clears state, and issue_ready=1 from the first cycle after reset, given hazard-free inputs.

Decomposition:
- rv32_pkg gains:
  - RF_NUM_REGS = 32 and RF_ADDR_W = 5.
  - SB_CNT_W = 2.
  - rv32_sb_issue_req_t, a struct of the issue_* source and destination fields, so the decode stage can drive it directly from rv32_instr_packet_t.
- Sub-module sb_reg_counter holds one CNT_W up/down counter:
  - inputs inc, dec, clr; outputs busy, at_max.
  - Instantiated NUM_REGS-1 times by generate; x0 is tied to not-busy.
- Hazard, ready and stall-counter logic lives in the top module.

Test Plan:
- Reset, then issue rd=5 with wen → busy_vec[5]=1 next cycle. Next instruction reads rs1=5 → issue_ready=0, hazard_rs1=1, stall_cnt increments each cycle.
- Pending x5 (cnt=1); wb_enable with wb_addr=5 while the reader still waits → issue_ready=0 in the wb cycle, 1 in the next, busy_vec[5]=0.
- Three fires with rd=7 (cnt=3); fourth write to x7 → sat_stall, issue_ready=0. One wb to 7 → ready next cycle, cnt returns to 3 after the fire.
- Same cycle: fire with rd=9 and wb to 9, with cnt[9]=1 → cnt stays 1, busy_vec[9]=1.
- rd=0 and rs1=0: no increment and no hazard. wb_addr=3 with cnt[3]=0 → wb_underflow=1 and stays 1 until reset.
- Pending x4, x6; flush=1 → issue_ready=0 that cycle, busy_vec=0 next cycle. Set stall_cnt to 16'hFFFE and stall 3 cycles → holds 16'hFFFF.
